draw_bg_fade: RTL and testbench

Parametrised background renderer for the game screen, with a palette and a frame-synchronous fade transition. It sits in the VGA pipeline after the sprite/foreground drawers. Key-colour pixels in the active area are replaced with a palette background, either solid or scrolling stripes. A start handshake fades the current background out, swaps to the new colour and mode at a frame boundary, and fades back in.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_if.sv | 13 +
 rtl/bg_fade_ctrl.sv | 104 ++++++++++
 rtl/draw_bg_fade.sv | 89 ++++++++
 tb/tb_draw_bg_fade.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: background palette, fade range, fade FSM states
// and the per-channel brightness scaler.
package vga_pkg;

  localparam logic [11:0] MENU_BG_COLOR = 12'h8C4;
  localparam int PALETTE_SIZE = 8;
  localparam int PALETTE_AW   = 3;

  localparam logic [11:0] BG_PALETTE [PALETTE_SIZE] = '{
    MENU_BG_COLOR, 12'h24A, 12'hF80, 12'h0F0,
    12'hF0F,       12'h0FF, 12'h888, 12'hFFF
  };

  localparam int FADE_MAX = 16;

  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} fade_state_t;

  // The 9-bit product never exceeds 240, so bits [7:4] are the scaled channel
  function automatic logic [3:0] scale_ch(input logic [3:0] ch, input logic [4:0] level);
    return 4'((9'(ch) * 9'(level)) >> 4);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between pipeline stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/bg_fade_ctrl.sv
// Frame-synchronous fade controller: detects frame ticks, steps the brightness
// level out and back in, and swaps palette index/mode at the darkest point.
module bg_fade_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_COLORS      = 4,
  parameter int FRAMES_PER_STEP = 2,
  localparam int CW = $clog2(NUM_COLORS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vblnk,
  input  logic [CW-1:0] color_sel,
  input  logic          mode_sel,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    level,
  output logic [CW-1:0] cur_idx,
  output logic          cur_mode,
  output logic [10:0]   scroll
);

  localparam int SCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(FRAMES_PER_STEP - 1);
  localparam logic [CW:0]    IDX_MAX   = (CW+1)'(NUM_COLORS - 1);

  fade_state_t   state;
  logic          vblnk_q;
  logic          frame_tick;
  logic          step_wrap;
  logic [SCW-1:0] step_cnt;
  logic [CW-1:0] pend_idx;
  logic [CW-1:0] sel_clamped;
  logic          pend_mode;

  assign frame_tick  = vblnk & ~vblnk_q;
  assign step_wrap   = frame_tick && (step_cnt == STEP_LAST);
  assign sel_clamped = ({1'b0, color_sel} > IDX_MAX) ? IDX_MAX[CW-1:0] : color_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  // Level, palette index and mode only move on frame ticks or in SWAP (inside vblank)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      level     <= 5'(FADE_MAX);
      cur_idx   <= '0;
      cur_mode  <= 1'b0;
      pend_idx  <= '0;
      pend_mode <= 1'b0;
      scroll    <= '0;
      step_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (frame_tick && cur_mode) scroll <= scroll + 11'd1;

      if ((state == FADE_OUT || state == FADE_IN) && frame_tick)
        step_cnt <= step_wrap ? '0 : step_cnt + SCW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            pend_idx  <= sel_clamped;
            pend_mode <= mode_sel;
            step_cnt  <= '0;
            busy      <= 1'b1;
            state     <= FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (step_wrap) begin
            level <= level - 5'd1;
            if (level == 5'd1) state <= SWAP;
          end
        end
        SWAP: begin
          cur_idx  <= pend_idx;
          cur_mode <= pend_mode;
          scroll   <= '0;
          step_cnt <= '0;
          state    <= FADE_IN;
        end
        FADE_IN: begin
          if (step_wrap) begin
            level <= level + 5'd1;
            if (level == 5'(FADE_MAX - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/draw_bg_fade.sv
// Background renderer: replaces key-colour pixels with a faded palette colour,
// solid or as scrolling stripes, and registers the whole VGA bundle.
module draw_bg_fade
  import vga_pkg::*;
#(
  parameter int          NUM_COLORS      = 4,
  parameter int          FRAMES_PER_STEP = 2,
  parameter int          STRIPE_W        = 32,
  parameter logic [11:0] KEY_COLOR       = 12'h000,
  localparam int CW = $clog2(NUM_COLORS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] color_sel,
  input  logic          mode_sel,
  input  logic          start,
  output logic          busy,
  output logic          done,
  vga_if.in             in,
  vga_if.out            out
);

  localparam int SB = $clog2(STRIPE_W);

  logic [4:0]    level;
  logic [CW-1:0] cur_idx;
  logic          cur_mode;
  logic [10:0]   scroll;
  logic          stripe_odd;
  logic [11:0]   base;
  logic [11:0]   bg;
  logic [11:0]   rgb_next;

  bg_fade_ctrl #(
    .NUM_COLORS      (NUM_COLORS),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (in.vblnk),
    .color_sel (color_sel),
    .mode_sel  (mode_sel),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .level     (level),
    .cur_idx   (cur_idx),
    .cur_mode  (cur_mode),
    .scroll    (scroll)
  );

  assign base       = BG_PALETTE[PALETTE_AW'(cur_idx)];
  assign stripe_odd = 1'((in.hcount + scroll) >> SB);
  assign bg = (cur_mode && stripe_odd)
            ? {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]}
            : base;

  // Foreground pixels bypass the fade; only key-colour pixels show the background
  always_comb begin
    rgb_next = 12'h000;
    if (in.vblnk || in.hblnk)
      rgb_next = 12'h000;
    else if (in.rgb != KEY_COLOR)
      rgb_next = in.rgb;
    else
      rgb_next = {scale_ch(bg[11:8], level), scale_ch(bg[7:4], level), scale_ch(bg[3:0], level)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_bg_fade.sv
// Self-checking bench for draw_bg_fade: short synthetic frames with random
// pixels, compared against a frame-count based fade model.
module tb_draw_bg_fade;

  localparam int NC  = 3;
  localparam int FPS = 1;
  localparam int SW  = 32;
  localparam logic [11:0] PAL [8] = '{
    12'h8C4, 12'h24A, 12'hF80, 12'h0F0, 12'hF0F, 12'h0FF, 12'h888, 12'hFFF
  };

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] color_sel;
  logic       mode_sel;
  logic       start;
  logic       busy;
  logic       done;

  vga_if vin ();
  vga_if vout ();

  draw_bg_fade #(
    .NUM_COLORS      (NC),
    .FRAMES_PER_STEP (FPS),
    .STRIPE_W        (SW),
    .KEY_COLOR       (12'h000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .color_sel (color_sel),
    .mode_sel  (mode_sel),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in        (vin),
    .out       (vout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int done_seen = 0;

  // model: transition progress measured in frame ticks since start
  bit m_active, m_swap, m_done, m_mode, m_pmode, vb_prev;
  int m_ticks, m_idx, m_pidx, m_scroll, m_level;

  task automatic modelReset();
    m_active = 0; m_swap = 0; m_done = 0; m_mode = 0; m_pmode = 0; vb_prev = 0;
    m_ticks = 0; m_idx = 0; m_pidx = 0; m_scroll = 0; m_level = 16;
  endtask

  function automatic int levelAfter(int t);
    if (t <= 16 * FPS) return 16 - t / FPS;
    return (t - 16 * FPS) / FPS;
  endfunction

  task automatic modelClock(input bit vb, input bit st, input int sel, input bit md);
    bit tick;
    bit was_active;
    tick = vb && !vb_prev;
    vb_prev = vb;
    was_active = m_active;
    m_done = 0;
    if (m_swap) begin
      m_idx = m_pidx; m_mode = m_pmode; m_scroll = 0; m_swap = 0;
    end else if (tick && m_mode) begin
      m_scroll = (m_scroll + 1) % 2048;
    end
    if (m_active && tick) begin
      m_ticks++;
      m_level = levelAfter(m_ticks);
      if (m_ticks == 16 * FPS) m_swap = 1;
      if (m_ticks == 32 * FPS) begin m_active = 0; m_done = 1; end
    end
    if (!was_active && st) begin
      m_active = 1; m_ticks = 0;
      m_pidx = (sel >= NC) ? NC - 1 : sel;
      m_pmode = md;
    end
  endtask

  function automatic logic [11:0] modelPixel(int h, bit hb, bit vb, logic [11:0] rgb);
    logic [11:0] base;
    int r, g, b;
    if (hb || vb) return 12'h000;
    if (rgb != 12'h000) return rgb;
    base = PAL[m_idx];
    r = int'(base[11:8]); g = int'(base[7:4]); b = int'(base[3:0]);
    if (m_mode && ((((h + m_scroll) % 2048) / SW) % 2 == 1)) begin
      r = r / 2; g = g / 2; b = b / 2;
    end
    r = r * m_level / 16; g = g * m_level / 16; b = b * m_level / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one pixel after a negedge, clocks it, and checks the registered result
  task automatic applyStimulus(input int h, input bit hb, input bit vb, input logic [11:0] rgb,
                               input bit st, input int sel, input bit md);
    logic [11:0] exp;
    vin.hcount = 11'(h);
    vin.vcount = vb ? 11'd600 : 11'd10;
    vin.hblnk = hb; vin.hsync = hb;
    vin.vblnk = vb; vin.vsync = vb;
    vin.rgb = rgb;
    start = st; color_sel = 2'(sel); mode_sel = md;
    exp = modelPixel(h, hb, vb, rgb);
    @(posedge clk);
    modelClock(vb, st, sel, md);
    #1;
    checkOutput("rgb", vout.rgb, exp);
    checkOutput("hcount", {1'b0, vout.hcount}, 12'(h));
    checkOutput("busy", {11'b0, busy}, {11'b0, m_active});
    checkOutput("done", {11'b0, done}, {11'b0, m_done});
    if (done) done_seen++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runFrame(input bit st, input int sel, input bit md);
    int hs [7] = '{0, 30, 31, 32, 33, 63, 64};
    int h;
    logic [11:0] rgb;
    for (int i = 0; i < 12; i++) begin
      h = (i < 7) ? hs[i] : int'($urandom_range(0, 2047));
      rgb = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
      applyStimulus(h, 0, 0, rgb, st && (i == 0), sel, md);
    end
    applyStimulus(800, 1, 0, 12'($urandom), 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 12'($urandom), 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; color_sel = 2'd0; mode_sel = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 0; vin.hsync = 0;
    vin.vblnk = 0; vin.vsync = 0; vin.rgb = '0;
    modelReset();
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_rgb", vout.rgb, 12'h000);
    checkOutput("reset_busy", {11'b0, busy}, 12'h000);
    checkOutput("reset_done", {11'b0, done}, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle rendering: menu colour, foreground passthrough
    runFrame(0, 0, 0);
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("idle_bg", vout.rgb, 12'h8C4);
    applyStimulus(6, 0, 0, 12'hF00, 0, 0, 0);
    checkOutput("fg_pass", vout.rgb, 12'hF00);

    // solid fade to colour 2, with the half-brightness point checked directly
    runFrame(1, 2, 0);
    repeat (7) runFrame(0, 0, 0);
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("level8", vout.rgb, 12'h462);
    repeat (27) runFrame(0, 0, 0);
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("after_t1", vout.rgb, 12'hF80);

    // stripes to colour 1; a second start mid-transition must be ignored
    runFrame(1, 1, 1);
    repeat (4) runFrame(0, 0, 0);
    runFrame(1, 0, 0);
    repeat (33) runFrame(0, 0, 0);
    checkOutput("done_count_t2", 12'(done_seen), 12'd2);

    // out-of-range colour select clamps to the last entry
    runFrame(1, 3, 0);
    repeat (33) runFrame(0, 0, 0);
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("clamp", vout.rgb, 12'hF80);

    // asynchronous reset in the middle of a fade-out
    runFrame(1, 1, 0);
    repeat (10) runFrame(0, 0, 0);
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    vin.vblnk = 0; vin.vsync = 0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rgb", vout.rgb, 12'h000);
    checkOutput("async_busy", {11'b0, busy}, 12'h000);
    checkOutput("async_done", {11'b0, done}, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(5, 0, 0, 12'h000, 0, 0, 0);
    checkOutput("post_reset_bg", vout.rgb, 12'h8C4);
    repeat (2) runFrame(0, 0, 0);
    checkOutput("done_count", 12'(done_seen), 12'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
